router_rx_port: RTL and testbench

//  Downstream consumer for one router output port (data_out_x / vld_out_x / read_enb_x).

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_rx_fifo.sv | 62 ++++++
 rtl/router_rx_port.sv | 156 +++++++++++++++
 tb/tb_router_rx_port.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared framing constants and FSM encoding for the router receive ports.
package router_pkg;

  localparam int DATA_W      = 8;
  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_ADDR_W  = 2;
  localparam int LEN_W       = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int REM_W       = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    BODY  = 2'd2,
    DRAIN = 2'd3
  } rx_state_e;

  // Bytes still to be read after the header: payload plus the parity byte.
  function automatic logic [REM_W-1:0] rem_init(input logic [DATA_W-1:0] hdr);
    return REM_W'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]) + REM_W'(1);
  endfunction

endpackage

// File: rtl/router_rx_fifo.sv
// Small synchronous FIFO of {last, data} entries; the head entry falls through
// onto the outputs so the consumer sees it without a read cycle.
module router_rx_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         push,
  input  logic [DATA_W:0]              push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output logic [DATA_W:0]              head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/router_rx_port.sv
// Drains framed packets from one router output port, strips header/parity,
// streams payload on valid/ready and reports per-packet status.
module router_rx_port
  import router_pkg::*;
#(
  parameter int OUT_DEPTH = 4,
  parameter int TIMEOUT   = 32
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  vld_out,
  input  logic [DATA_W-1:0]     data_out,
  output logic                  read_enb,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [HDR_ADDR_W-1:0] pkt_addr,
  output logic [LEN_W-1:0]      pkt_len,
  output logic                  pkt_done,
  output logic                  pkt_err,
  output logic                  pkt_abort
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  rx_state_e        state_q;
  rx_state_e        state_d;
  logic             vld_p1;
  logic             armed_q;
  logic [REM_W-1:0] rem_q;
  logic [DATA_W-1:0] par_q;
  logic             par_err_q;
  logic [WD_W-1:0]  wd_q;
  logic [CNT_W-1:0] buf_count;
  logic [DATA_W:0]  fifo_head;
  logic             fifo_push;
  logic             fifo_flush;
  logic             fifo_pop;
  logic             in_pkt;
  logic             timeout;
  logic             room;
  logic             parity_byte;

  assign in_pkt      = (state_q == HDR) || (state_q == BODY);
  assign timeout     = in_pkt && (wd_q == WD_W'(TIMEOUT));
  assign room        = ((CNT_W+1)'(buf_count) + (CNT_W+1)'(vld_p1)) < (CNT_W+1)'(OUT_DEPTH);
  assign parity_byte = (rem_q == REM_W'(1));
  assign fifo_pop    = m_valid && m_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (armed_q && vld_out) state_d = HDR;
      HDR:   if (timeout) state_d = IDLE;
             else if (vld_p1) state_d = BODY;
      BODY:  if (timeout) state_d = IDLE;
             else if (vld_p1 && parity_byte) state_d = DRAIN;
      DRAIN: if (buf_count == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_enb   = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    pkt_done   = 1'b0;
    pkt_err    = 1'b0;
    pkt_abort  = 1'b0;
    case (state_q)
      IDLE: read_enb = armed_q && vld_out;
      HDR: begin
        if (timeout) begin
          fifo_flush = 1'b1;
          pkt_done   = 1'b1;
          pkt_err    = 1'b1;
          pkt_abort  = 1'b1;
        end
      end
      BODY: begin
        if (timeout) begin
          fifo_flush = 1'b1;
          pkt_done   = 1'b1;
          pkt_err    = 1'b1;
          pkt_abort  = 1'b1;
        end else begin
          // Never request past the parity byte, counting the one already in flight.
          read_enb  = vld_out && (rem_q > REM_W'(vld_p1)) && room;
          fifo_push = vld_p1 && !parity_byte;
        end
      end
      DRAIN: begin
        if (buf_count == '0) begin
          pkt_done = 1'b1;
          pkt_err  = par_err_q;
        end
      end
      default: ;
    endcase
  end

  // Capture stage: data_out is valid the cycle after read_enb (vld_p1).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      armed_q   <= 1'b0;
      vld_p1    <= 1'b0;
      rem_q     <= '0;
      par_q     <= '0;
      par_err_q <= 1'b0;
      wd_q      <= '0;
      pkt_addr  <= '0;
      pkt_len   <= '0;
    end else begin
      armed_q <= 1'b1;
      vld_p1  <= read_enb;
      if (state_q == HDR && vld_p1) begin
        pkt_addr  <= data_out[HDR_ADDR_W-1:0];
        pkt_len   <= data_out[HDR_LEN_MSB:HDR_LEN_LSB];
        par_q     <= data_out;
        rem_q     <= rem_init(data_out);
        par_err_q <= 1'b0;
      end else if (state_q == BODY && vld_p1) begin
        rem_q <= rem_q - REM_W'(1);
        if (parity_byte) par_err_q <= (data_out != par_q);
        else             par_q     <= par_q ^ data_out;
      end
      if (!in_pkt || vld_p1)                   wd_q <= '0;
      else if (!vld_out && !timeout)           wd_q <= wd_q + WD_W'(1);
    end
  end

  router_rx_fifo #(
    .DEPTH(OUT_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push       (fifo_push),
    .push_entry ({(rem_q == REM_W'(2)), data_out}),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .head       (fifo_head),
    .valid      (m_valid),
    .count      (buf_count)
  );

  assign m_last = fifo_head[DATA_W];
  assign m_data = fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_router_rx_port.sv
// Scoreboard bench for router_rx_port: a router-port model feeds framed packets,
// a monitor checks payload beats and packet status against queued expectations.
module tb_router_rx_port;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_out = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       read_enb;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b0;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  logic       pkt_done;
  logic       pkt_err;
  logic       pkt_abort;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rq[$];   // bytes waiting in the router port FIFO
  logic [8:0] dq[$];   // expected {last, data} beats
  logic [9:0] sq[$];   // expected {err, abort, addr, len}

  router_rx_port #(.OUT_DEPTH(4), .TIMEOUT(32)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .vld_out  (vld_out),
    .data_out (data_out),
    .read_enb (read_enb),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .pkt_addr (pkt_addr),
    .pkt_len  (pkt_len),
    .pkt_done (pkt_done),
    .pkt_err  (pkt_err),
    .pkt_abort(pkt_abort)
  );

  always #5 clock = ~clock;

  // Router port: one-cycle read latency, vld_out reflects bytes still queued.
  always @(posedge clock) begin
    if (read_enb) begin
      if (rq.size() != 0) begin
        data_out <= rq.pop_front();
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL router_read: read_enb=1 with router empty, required read_enb=0");
      end
    end
    vld_out <= (rq.size() != 0);
  end

  // Monitor: compares every transfer and every status pulse against the queues.
  always @(negedge clock) begin
    if (resetn) begin
      if (m_valid && m_ready) begin
        vectors++;
        if (dq.size() == 0) begin
          miscompares++;
          $display("FAIL beat: unexpected beat last=%0d data=%h, required no beat", m_last, m_data);
        end else begin
          logic [8:0] e;
          e = dq.pop_front();
          if ({m_last, m_data} !== e) begin
            miscompares++;
            $display("FAIL beat: got last=%0d data=%h, required last=%0d data=%h",
                     m_last, m_data, e[8], e[7:0]);
          end
        end
      end
      if (pkt_done) begin
        vectors++;
        if (sq.size() == 0) begin
          miscompares++;
          $display("FAIL status: unexpected pkt_done err=%0d abort=%0d, required none",
                   pkt_err, pkt_abort);
        end else begin
          logic [9:0] s;
          s = sq.pop_front();
          if ({pkt_err, pkt_abort, pkt_addr, pkt_len} !== s) begin
            miscompares++;
            $display("FAIL status: got err=%0d abort=%0d addr=%0d len=%0d, required err=%0d abort=%0d addr=%0d len=%0d",
                     pkt_err, pkt_abort, pkt_addr, pkt_len, s[9], s[8], s[7:6], s[5:0]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Queue a packet into the router model and its expectations into the scoreboard.
  // nbody limits how many payload bytes the router ever offers (abort tests).
  task automatic push_pkt(input logic [1:0] addr, input logic [5:0] len,
                          input logic [7:0] base, input logic [7:0] par_flip,
                          input int nbody, input logic abort);
    logic [7:0] hdr;
    logic [7:0] par;
    logic [7:0] b;
    hdr = {len, addr};
    par = hdr;
    rq.push_back(hdr);
    for (int i = 0; i < int'(len); i++) begin
      b = base + 8'(i);
      par = par ^ b;
      if (i < nbody) rq.push_back(b);
      if (!abort) dq.push_back({(i == int'(len) - 1), b});
    end
    if (!abort) rq.push_back(par ^ par_flip);
    sq.push_back({(par_flip != 8'h00) || abort, abort, addr, len});
  endtask

  task automatic wait_idle(input int max, input string name);
    int n;
    n = 0;
    while ((sq.size() != 0 || dq.size() != 0) && n < max) begin
      step();
      n++;
    end
    if (n >= max) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout with %0d status and %0d beats outstanding, required 0",
               name, sq.size(), dq.size());
      sq.delete();
      dq.delete();
    end
  endtask

  initial begin
    // Reset held with the router already offering a packet.
    m_ready = 1'b1;
    push_pkt(2'd2, 6'd7, 8'h11, 8'h00, 7, 1'b0);
    repeat (3) step();
    @(negedge clock);
    chk("rst_vld_out_seen", 32'(vld_out), 32'd1);
    chk("rst_read_enb", 32'(read_enb), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    step();
    resetn = 1'b1;
    wait_idle(200, "pkt_basic");
    step();
    chk("basic_addr_hold", 32'(pkt_addr), 32'd2);
    chk("basic_len_hold", 32'(pkt_len), 32'd7);

    // Corrupted parity: same payload, error flagged.
    push_pkt(2'd2, 6'd7, 8'h11, 8'h01, 7, 1'b0);
    wait_idle(200, "pkt_parity");

    // Sink stall: buffer fills to depth and reads stop, data held stable.
    m_ready = 1'b0;
    push_pkt(2'd1, 6'd7, 8'h40, 8'h00, 7, 1'b0);
    repeat (15) step();
    m_ready = 1'b1;
    step();
    step();
    m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c >= 10) begin
        @(negedge clock);
        chk("stall_read_enb", 32'(read_enb), 32'd0);
        chk("stall_m_valid", 32'(m_valid), 32'd1);
        chk("stall_hold", 32'({m_last, m_data}), 32'h042);
      end
    end
    m_ready = 1'b1;
    wait_idle(200, "pkt_stall");

    // Zero-length packet: header 01, parity 01.
    push_pkt(2'd1, 6'd0, 8'h00, 8'h00, 0, 1'b0);
    wait_idle(100, "pkt_len0");
    step();
    chk("len0_addr", 32'(pkt_addr), 32'd1);
    chk("len0_len", 32'(pkt_len), 32'd0);

    // Back-to-back packets.
    push_pkt(2'd1, 6'd2, 8'hC0, 8'h00, 2, 1'b0);
    push_pkt(2'd2, 6'd1, 8'hD0, 8'h00, 1, 1'b0);
    wait_idle(200, "pkt_b2b");

    // Router goes quiet mid-packet: watchdog abort flushes buffered payload.
    m_ready = 1'b0;
    push_pkt(2'd3, 6'd7, 8'h80, 8'h00, 3, 1'b1);
    wait_idle(150, "pkt_abort");
    step();
    @(negedge clock);
    chk("abort_flushed", 32'(m_valid), 32'd0);
    chk("abort_addr", 32'(pkt_addr), 32'd3);
    m_ready = 1'b1;
    step();
    push_pkt(2'd0, 6'd3, 8'hA0, 8'h00, 3, 1'b0);
    wait_idle(200, "pkt_after_abort");
    step();
    chk("after_abort_addr", 32'(pkt_addr), 32'd0);
    chk("after_abort_len", 32'(pkt_len), 32'd3);

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
